// File: rtl/valve_policy_driver.sv
// valve_policy_driver: looks up a trained valve target for each accepted
// state address, slews valve_out toward it in bounded steps, then holds it
// for a settle period before the next address is accepted.
// Optional build macro VALVE_LIMIT_EN clamps every looked-up target to VALVE_MAX.
module valve_policy_driver #(
   parameter int unsigned ADDR_W        = 9,
   parameter int unsigned VALVE_W       = 6,
   parameter int unsigned STEP          = 2,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned VALVE_MAX     = 48
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [ADDR_W-1:0]  addr_in,
   input  logic               addr_valid,
   output logic               addr_ready,
   input  logic               wr_en,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [VALVE_W-1:0] wr_data,
   output logic [VALVE_W-1:0] valve_out,
   output logic [VALVE_W-1:0] target_out,
   output logic               busy,
   output logic               settled
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [VALVE_W-1:0] STEP_V   = VALVE_W'(STEP);
   localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOOKUP = 2'd1,
      S_SLEW   = 2'd2,
      S_SETTLE = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [VALVE_W-1:0] valve_q, valve_d;
   logic [VALVE_W-1:0] target_q, target_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               settled_q, settled_d;
   logic [DEPTH-1:0]   written_q, written_d;
   logic [VALVE_W-1:0] mem_q [DEPTH];
   logic [VALVE_W-1:0] lookup_c;
   logic [VALVE_W-1:0] diff_c;

`ifdef VALVE_LIMIT_EN
   localparam logic [VALVE_W-1:0] LIMIT = VALVE_W'(VALVE_MAX);
   logic [VALVE_W-1:0] raw_c;

   // Table entry (or hold value when unwritten), clamped to the limit
   always_comb begin
      raw_c    = written_q[addr_q] ? mem_q[addr_q] : valve_q;
      lookup_c = (raw_c > LIMIT) ? LIMIT : raw_c;
   end
`else
   logic unused_valve_max;
   assign unused_valve_max = ^32'(VALVE_MAX);

   // Table entry, or hold the current valve when the entry was never written
   always_comb begin
      lookup_c = written_q[addr_q] ? mem_q[addr_q] : valve_q;
   end
`endif

   // Policy table storage; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Per-entry written flags: set on write, cleared by reset
   always_comb begin
      written_d = written_q;
      if (wr_en) begin
         written_d[wr_addr] = 1'b1;
      end
   end

   // Distance between target and current valve drive
   always_comb begin
      diff_c = (target_q > valve_q) ? (target_q - valve_q) : (valve_q - target_q);
   end

   // Next-state and datapath updates
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      valve_d  = valve_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (addr_valid) begin
               addr_d  = addr_in;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            target_d = lookup_c;
            if (lookup_c == valve_q) begin
               state_d = S_SETTLE;
               cnt_d   = CNT_LOAD;
            end else begin
               state_d = S_SLEW;
            end
         end
         S_SLEW: begin
            if (diff_c <= STEP_V) begin
               valve_d = target_q;
               state_d = S_SETTLE;
               cnt_d   = CNT_LOAD;
            end else if (target_q > valve_q) begin
               valve_d = valve_q + STEP_V;
            end else begin
               valve_d = valve_q - STEP_V;
            end
         end
         S_SETTLE: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d    = (state_d != S_IDLE);
      settled_d = (state_d == S_SETTLE) && (cnt_d == '0);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         valve_q   <= '0;
         target_q  <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         settled_q <= 1'b0;
         written_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         valve_q   <= valve_d;
         target_q  <= target_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         settled_q <= settled_d;
         written_q <= written_d;
      end
   end

   assign addr_ready = (state_q == S_IDLE);
   assign valve_out  = valve_q;
   assign target_out = target_q;
   assign busy       = busy_q;
   assign settled    = settled_q;

endmodule

// File: doc/valve_policy_driver.md
Name: valve_policy_driver

Overview:
- Downstream consumer of the data sorter's 9-bit state address ({Temp_state, change_state, time_state}).
- Holds the trained valve-policy table (512 x 6-bit, loaded through a write port) and looks up the target valve setting for each accepted address.
- Drives the physical valve output toward that target with a bounded step per cycle, then enforces a settle period before accepting the next address.
- Sits between data_sorter and the valve actuator interface.

Parameters:
- ADDR_W, 9, width of state address and table index (table depth 2^ADDR_W).
- VALVE_W, 6, width of valve setting.
- STEP, 2, maximum change of valve_out per cycle while slewing; must be >=1.
- SETTLE_CYCLES, 4, cycles valve_out is held stable after reaching target; must be >=1.
- VALVE_MAX, 48, upper clamp on target (used only with VALVE_LIMIT_EN).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- addr_in  in  ADDR_W  state address from data sorter.
- addr_valid  in  1  addr_in is valid this cycle.
- addr_ready  out  1  block accepts addr_in this cycle (combinational, high only in IDLE).
- wr_en  in  1  table write strobe.
- wr_addr  in  ADDR_W  table write index.
- wr_data  in  VALVE_W  table write data.
- valve_out  out  VALVE_W  registered valve drive.
- target_out  out  VALVE_W  registered current target.
- busy  out  1  high in LOOKUP/SLEW/SETTLE.
- settled  out  1  one-cycle pulse on the last SETTLE cycle.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; valve_out=0, target_out=0, busy=0, settled=0, settle counter=0, per-entry written-flag vector cleared. Table data is not reset.
- Handshake: transfer when addr_valid && addr_ready. addr_ready = (state==IDLE). No queueing; addresses offered while busy are ignored.
- FSM:
  - IDLE --transfer--> LOOKUP. The address is registered.
  - LOOKUP (1 cycle): table read.
    - If the entry's written flag=0: target = current valve_out (hold).
    - Else: target = table data.
    - target_out is updated at the end of LOOKUP.
    - Next state is SLEW, or SETTLE directly if target == valve_out.
  - SLEW, each cycle with diff = |target - valve_out|:
    - If diff <= STEP: valve_out = target, go to SETTLE.
    - Else: valve_out moves toward target by exactly STEP.
    - Unsigned arithmetic, no wrap: never below 0 or above 2^VALVE_W-1.
  - SETTLE: counter loads SETTLE_CYCLES-1 on entry and decrements each cycle. settled=1 in the cycle the counter is 0; the next state is IDLE.
- Latency from accept to settled pulse = 1 (LOOKUP) + slew cycles + SETTLE_CYCLES. Slew cycles = ceil(diff/STEP), or 0 if diff=0.
- Writes:
  - Accepted in any state. Take effect at the clock edge: data stored, written flag set.
  - Write to the LOOKUP address in the LOOKUP cycle: the lookup returns pre-write contents (read-before-write).
  - A write never alters the target of an operation already past LOOKUP.
- Simultaneous addr_valid in the settled cycle: not accepted (addr_ready=0). Acceptance is possible from the following IDLE cycle.
- Reset mid-operation: immediate return to reset values. The table keeps its data but all entries read as unwritten until rewritten.

Optional Feature:
- Macro VALVE_LIMIT_EN.
- Defined: the looked-up target is clamped to min(entry, VALVE_MAX) before being stored into target_out and used for slewing. This includes the hold case.
- Undefined: no clamp; VALVE_MAX is unused.

Test Plan:
- Reset, write table[0x049]=20, offer addr 0x049 with valve_out=0, STEP=2 -> LOOKUP 1 cycle, target_out=20, valve_out steps 2,4,...,20 over 10 cycles, settled pulses 4 cycles later, addr_ready returns high next cycle.
- Offer unwritten addr 0x1FF with valve_out=20 -> target_out=20, no slew, straight to SETTLE, settled after 1+4 cycles.
- Write table[0x092]=7 while valve_out=20 -> slew 18,16,...,8 then 7 (final partial step of 1), never undershoots.
- Hold addr_valid high with alternating addresses during SLEW -> ignored, addr_ready=0, valve_out trajectory unchanged.
- wr_en to the LOOKUP address with new data in the LOOKUP cycle -> old value used as target; the next access to the same address uses the new value.
- With VALVE_LIMIT_EN and table entry 63 -> target_out=48, valve_out stops at 48. Assert rst_n=0 mid-slew -> valve_out=0 asynchronously, busy=0.
